// File: rtl/wb_frame_checker.sv
// rtl/wb_frame_checker.sv - Wishbone write-only PRBS-7 frame checker
// Counts matching and mismatching bits per frame and holds the results until cleared.
module wb_frame_checker #(
  parameter int         FRAME_LEN = 104,
  parameter int         TIMEOUT   = 64,
  parameter logic [6:0] SEED      = 7'h7F
) (
  input  logic       cl05,
  input  logic       RST_Ii,
  input  logic [3:0] DAT_I,
  input  logic       CYC_I,
  input  logic       STB_I,
  input  logic       WE_I,
  output logic       ACK_O,
  input  logic       clr,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic [6:0] word_cnt,
  output logic [9:0] err_bits,
  output logic [9:0] ok_bits
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t     state, state_nxt;
  logic       acc;
  logic       last_word;
  logic       stall;
  logic       frame_end;
  logic       abort;
  logic [7:0] idle_cnt;
  logic [6:0] prbs, prbs_nxt, prbs_walk;
  logic [3:0] exp_nib;
  logic [3:0] diff;
  logic [2:0] err_inc;
  logic [2:0] ok_inc;

  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [2:0] b);
    logic [10:0] sum;
    sum = {1'b0, a} + {8'd0, b};
    return sum[10] ? 10'h3FF : sum[9:0];
  endfunction

  assign acc       = CYC_I & STB_I & WE_I & ~clr & (state != HOLD);
  assign ACK_O     = acc;
  assign last_word = (word_cnt == 7'(FRAME_LEN - 1));
  // Abort on the edge that would take the idle counter to TIMEOUT.
  assign stall     = (state == RUN) && !acc && (idle_cnt == 8'(TIMEOUT - 1));

  // Four LFSR steps per word; the first generated bit lands on DAT_I[3].
  always_comb begin
    prbs_walk = prbs;
    exp_nib   = '0;
    for (int i = 0; i < 4; i++) begin
      exp_nib[3-i] = prbs_walk[6] ^ prbs_walk[5];
      prbs_walk    = {prbs_walk[5:0], prbs_walk[6] ^ prbs_walk[5]};
    end
    prbs_nxt = prbs_walk;
  end

  assign diff    = DAT_I ^ exp_nib;
  assign err_inc = {2'b00, diff[0]} + {2'b00, diff[1]} + {2'b00, diff[2]} + {2'b00, diff[3]};
  assign ok_inc  = 3'd4 - err_inc;

  always_ff @(posedge cl05 or negedge RST_Ii) begin
    if (!RST_Ii) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    abort     = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            state_nxt = last_word ? HOLD : RUN;
            frame_end = last_word;
          end
        end
        RUN: begin
          if (acc && last_word) begin
            state_nxt = HOLD;
            frame_end = 1'b1;
          end else if (stall) begin
            state_nxt = HOLD;
            frame_end = 1'b1;
            abort     = 1'b1;
          end
        end
        HOLD:    state_nxt = HOLD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge cl05 or negedge RST_Ii) begin
    if (!RST_Ii) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      word_cnt   <= '0;
      err_bits   <= '0;
      ok_bits    <= '0;
      idle_cnt   <= '0;
      prbs       <= SEED;
    end else begin
      busy       <= (state_nxt == RUN);
      frame_done <= frame_end;
      if (clr) begin
        frame_err <= 1'b0;
        word_cnt  <= '0;
        err_bits  <= '0;
        ok_bits   <= '0;
        idle_cnt  <= '0;
        prbs      <= SEED;
      end else if (acc) begin
        word_cnt <= word_cnt + 7'd1;
        err_bits <= sat_add(err_bits, err_inc);
        ok_bits  <= sat_add(ok_bits, ok_inc);
        idle_cnt <= '0;
        prbs     <= prbs_nxt;
      end else if (abort) begin
        frame_err <= 1'b1;
        idle_cnt  <= '0;
      end else if (state == RUN) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_frame_checker.sv
// tb/tb_wb_frame_checker.sv - self-checking bench for wb_frame_checker
// Reference nibbles come from the PRBS-7 bit recurrence x[j] = x[j-7] ^ x[j-6].
module tb_wb_frame_checker;

  logic       cl05 = 1'b0;
  logic       RST_Ii = 1'b0;
  logic [3:0] DAT_I = '0;
  logic       CYC_I = 1'b0;
  logic       STB_I = 1'b0;
  logic       WE_I = 1'b0;
  logic       ACK_O;
  logic       clr = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [6:0] word_cnt;
  logic [9:0] err_bits;
  logic [9:0] ok_bits;

  int n_cmp = 0;
  int n_fail = 0;
  logic x_seq [0:1023];

  wb_frame_checker dut (
    .cl05(cl05), .RST_Ii(RST_Ii), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .ACK_O(ACK_O), .clr(clr), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .word_cnt(word_cnt), .err_bits(err_bits), .ok_bits(ok_bits)
  );

  always #5 cl05 = ~cl05;

  function automatic logic [3:0] ref_nib(input int w);
    logic [3:0] n;
    for (int b = 0; b < 4; b++) n[3-b] = x_seq[7 + 4*w + b];
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check combinational ACK, then step past the edge.
  task automatic put(input logic c, input logic s, input logic w, input logic [3:0] d,
                     input logic cl, input logic exp_ack, input string tag);
    CYC_I = c; STB_I = s; WE_I = w; DAT_I = d; clr = cl;
    #1;
    check(tag, ACK_O, exp_ack);
    @(posedge cl05); #1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, "idle_ack");
  endtask

  // mode 0 clean, 1 all inverted, 2 single error on word 10 bit 0, 3 random errors and gaps
  task automatic send(input int n, input int start, input int mode, inout int exp_err);
    logic [3:0] m;
    int sel;
    for (int k = start; k < start + n; k++) begin
      case (mode)
        1:       m = 4'hF;
        2:       m = (k == 10) ? 4'h1 : 4'h0;
        3:       m = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        default: m = 4'h0;
      endcase
      if (mode == 3 && $urandom_range(0, 3) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 5)); g++) begin
          sel = int'($urandom_range(0, 2));
          put(sel != 0, sel != 1, sel != 2, 4'($urandom), 1'b0, 1'b0, "gap_ack");
        end
      end
      exp_err += $countones(m);
      put(1'b1, 1'b1, 1'b1, ref_nib(k) ^ m, 1'b0, 1'b1, "word_ack");
    end
  endtask

  task automatic check_counts(input string tag, input int wc, input int eb, input int ob);
    check({tag, "_word_cnt"}, word_cnt, wc);
    check({tag, "_err_bits"}, err_bits, eb);
    check({tag, "_ok_bits"}, ok_bits, ob);
  endtask

  task automatic do_clr;
    put(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "clr_ack");
  endtask

  initial begin
    int ee;
    logic [6:0] seed_v;
    seed_v = 7'h7F;
    for (int j = 0; j < 7; j++) x_seq[j] = seed_v[6-j];
    for (int j = 7; j < 1024; j++) x_seq[j] = x_seq[j-7] ^ x_seq[j-6];

    #22;
    check("rst_ack", ACK_O, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_ferr", frame_err, 0);
    check_counts("rst", 0, 0, 0);
    @(posedge cl05); #1;
    RST_Ii = 1'b1;
    @(posedge cl05); #1;

    // clean frame, split to observe busy one word before the end
    ee = 0;
    send(103, 0, 0, ee);
    check("clean_busy_mid", busy, 1);
    check("clean_done_mid", frame_done, 0);
    send(1, 103, 0, ee);
    check("clean_done", frame_done, 1);
    check("clean_busy_drop", busy, 0);
    check_counts("clean", 104, 0, 416);
    idle(1);
    check("clean_done_pulse", frame_done, 0);

    // writes in HOLD are ignored
    for (int i = 0; i < 5; i++) put(1'b1, 1'b1, 1'b1, 4'($urandom), 1'b0, 1'b0, "hold_ack");
    check_counts("hold", 104, 0, 416);
    check("hold_done", frame_done, 0);

    // clr together with a strobe
    put(1'b1, 1'b1, 1'b1, ref_nib(0), 1'b1, 1'b0, "clrstb_ack");
    check_counts("clrstb", 0, 0, 0);
    check("clrstb_busy", busy, 0);

    ee = 0;
    send(104, 0, 2, ee);
    check("single_done", frame_done, 1);
    check_counts("single", 104, 1, 415);
    do_clr();

    ee = 0;
    send(104, 0, 1, ee);
    check_counts("invert", 104, 416, 0);
    do_clr();

    for (int f = 0; f < 3; f++) begin
      ee = 0;
      send(104, 0, 3, ee);
      check("rand_done", frame_done, 1);
      check("rand_ferr", frame_err, 0);
      check_counts("rand", 104, ee, 416 - ee);
      do_clr();
    end

    // stall abort after 64 idle cycles
    ee = 0;
    send(50, 0, 3, ee);
    idle(63);
    check("stall_done_early", frame_done, 0);
    check("stall_busy_early", busy, 1);
    idle(1);
    check("stall_done", frame_done, 1);
    check("stall_ferr", frame_err, 1);
    check("stall_busy", busy, 0);
    check_counts("stall", 50, ee, 200 - ee);
    idle(3);
    for (int i = 0; i < 2; i++) put(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, "stall_hold_ack");
    check("stall_ferr_sticky", frame_err, 1);
    check("stall_done_once", frame_done, 0);
    check_counts("stall_frozen", 50, ee, 200 - ee);
    do_clr();
    check("stall_ferr_clr", frame_err, 0);

    // 63 idle cycles do not abort
    ee = 0;
    send(50, 0, 0, ee);
    idle(63);
    check("near_done", frame_done, 0);
    send(54, 50, 0, ee);
    check("near_done_end", frame_done, 1);
    check("near_ferr", frame_err, 0);
    check_counts("near", 104, 0, 416);
    do_clr();

    // asynchronous reset mid-frame
    ee = 0;
    send(60, 0, 0, ee);
    check("mid_wc", word_cnt, 60);
    #2;
    RST_Ii = 1'b0;
    #1;
    check("arst_ack", ACK_O, 0);
    check("arst_busy", busy, 0);
    check("arst_done", frame_done, 0);
    check("arst_ferr", frame_err, 0);
    check_counts("arst", 0, 0, 0);
    @(posedge cl05); @(posedge cl05); #1;
    RST_Ii = 1'b1;
    @(posedge cl05); #1;
    ee = 0;
    send(104, 0, 0, ee);
    check_counts("post_rst", 104, 0, 416);
    do_clr();

    // reads are never acknowledged
    for (int i = 0; i < 10; i++) put(1'b1, 1'b1, 1'b0, 4'($urandom), 1'b0, 1'b0, "read_ack");
    check_counts("read", 0, 0, 0);
    check("read_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
